chacha_block_sequencer: RTL and testbench
=========================================

Name: chacha_block_sequencer

Overview:
Multi-block job controller for the ChaCha20 core. It accepts a job (base counter, block count) and issues one core start per 64-byte block. It presents the block counter to the core and waits for core completion. It holds each finished block until downstream consumes it, then advances the counter. It sits between the top-level control FSM and the ChaCha20 core, replacing the single-block start/done sequencing for messages longer than one block.

Parameters:
BLK_W, 16, width of job_blocks and blocks_done (max job = 2^BLK_W-1 blocks)
TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_CORE before timeout error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  sequencer can accept a job (registered, 1 only in IDLE)
job_blocks  in  BLK_W  number of blocks in the job
job_counter  in  32  counter value for the first block
abort  in  1  terminate current job
core_start  out  1  one-cycle start pulse to the core
core_counter  out  32  counter for the current block, stable from start until done
core_busy  in  1  core is processing
core_done  in  1  core completion pulse
blk_valid  out  1  current block ciphertext is available downstream
blk_ready  in  1  downstream consumed the block
busy  out  1  job in progress
done  out  1  one-cycle job-end pulse
blocks_done  out  BLK_W  blocks consumed in the current/last job
err_wrap  out  1  job stopped because the counter would pass 0xFFFFFFFF (sticky until next job accept)
err_timeout  out  1  core_done not seen within TIMEOUT_CYCLES (sticky until next job accept)
err_abort  out  1  job ended by abort (sticky until next job accept)

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0) values:
  - state=IDLE, job_ready=1.
  - core_start, blk_valid, busy, done = 0.
  - core_counter=0, blocks_done=0.
  - All err flags = 0.
  - Internal remaining, watchdog = 0.
- Reset mid-job abandons the job immediately. No done pulse is generated.
- States: IDLE, START, WAIT_CORE, DRAIN, FINISH.
- IDLE:
  - job_ready=1, busy=0.
  - On job_valid&&job_ready:
    - Latch remaining=job_blocks and core_counter=job_counter.
    - Clear blocks_done and all err flags.
    - Set job_ready=0 and busy=1.
    - If job_blocks==0, go to FINISH (done pulse, blocks_done=0, no core_start). Otherwise go to START.
  - core_done and blk_ready are ignored in IDLE.
- START:
  - If core_busy=1, wait.
  - Otherwise assert core_start for exactly one cycle, clear watchdog, and go to WAIT_CORE.
  - Latency from job accept to the first core_start is 2 cycles when core_busy=0.
- WAIT_CORE:
  - watchdog increments every cycle.
  - On core_done: set blk_valid=1 and go to DRAIN.
  - Otherwise, if watchdog==TIMEOUT_CYCLES-1: set err_timeout=1 and go to FINISH.
  - If core_done and the timeout coincide, core_done wins.
- DRAIN:
  - blk_valid is held at 1 until blk_ready=1. blk_ready may be tied high.
  - On handshake:
    - blk_valid=0, blocks_done+1, remaining-1.
    - If remaining was 1, go to FINISH.
    - Else if core_counter==32'hFFFFFFFF, set err_wrap=1 and go to FINISH. The counter never wraps to 0.
    - Else core_counter+1 and go to START.
  - Best case is 3 cycles per block plus core latency.
- FINISH:
  - done=1 for one cycle, busy=0, job_ready=1 next cycle, go to IDLE.
  - blocks_done and err flags hold their values until the next job accept.
- abort:
  - Sampled in START, WAIT_CORE and DRAIN. It has priority over all other transitions in those states.
  - Next state is FINISH with err_abort=1. core_start is suppressed in the abort cycle.
  - blk_valid drops to 0. blocks_done is not incremented even if blk_ready coincides.
  - A core run already in flight completes. Its late core_done arrives in IDLE and is ignored.
- abort in IDLE or FINISH is ignored.
- job_valid during a job is not accepted (job_ready=0). The requester holds job_valid and the job fields stable until accepted.
- Counter arithmetic is 32-bit unsigned. blocks_done and remaining are BLK_W-bit and cannot overflow because blocks_done<=job_blocks.

Test Plan:
1. Single block: job_counter=0x00000001, job_blocks=1, core_done 10 cycles after start, blk_ready=1 -> one core_start with core_counter=1, one blk_valid handshake, done pulse, blocks_done=1, no errors.
2. Multi-block with backpressure: job_counter=5, job_blocks=4, blk_ready low 3 cycles each block -> core_counter sequence 5,6,7,8; blk_valid held through stalls; no core_start while blk_valid=1; blocks_done=4.
3. Counter limit: job_counter=0xFFFFFFFE, job_blocks=3 -> blocks use 0xFFFFFFFE and 0xFFFFFFFF, then err_wrap=1, done, blocks_done=2, only 2 core_start pulses.
4. Timeout: TIMEOUT_CYCLES=16, core_done never asserted -> err_timeout=1 and done exactly 16 cycles after WAIT_CORE entry, blocks_done=0; new job accepted next clears err_timeout.
5. Abort and stale done: job_blocks=8, abort in WAIT_CORE of block 2 -> FINISH, err_abort=1, blocks_done=1; core_done arriving 3 cycles later in IDLE produces no blk_valid or state change.
6. Edge cases: job_blocks=0 -> done pulse with no core_start. core_busy=1 during START -> core_start delayed until core_busy=0. rst_n low in DRAIN -> all outputs return to reset values asynchronously, with no done pulse.

Source files
------------

// File: rtl/chacha_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// chacha_block_sequencer_if : job / core / block-output bundle of the ChaCha20 block sequencer
// Rev 1.0
// ============================================================================
interface chacha_block_sequencer_if #(
  parameter int BLK_W = 16
);
  logic             job_valid;
  logic             job_ready;
  logic [BLK_W-1:0] job_blocks;
  logic [31:0]      job_counter;
  logic             abort;
  logic             core_start;
  logic [31:0]      core_counter;
  logic             core_busy;
  logic             core_done;
  logic             blk_valid;
  logic             blk_ready;
  logic             busy;
  logic             done;
  logic [BLK_W-1:0] blocks_done;
  logic             err_wrap;
  logic             err_timeout;
  logic             err_abort;

  modport slave (
    input  job_valid, job_blocks, job_counter, abort, core_busy, core_done, blk_ready,
    output job_ready, core_start, core_counter, blk_valid, busy, done, blocks_done,
           err_wrap, err_timeout, err_abort
  );

  modport master (
    output job_valid, job_blocks, job_counter, abort, core_busy, core_done, blk_ready,
    input  job_ready, core_start, core_counter, blk_valid, busy, done, blocks_done,
           err_wrap, err_timeout, err_abort
  );
endinterface
`default_nettype wire

// File: rtl/chacha_block_sequencer.sv
`default_nettype none
// ============================================================================
// chacha_block_sequencer : issues one ChaCha20 core run per block of a multi-block job
// Rev 1.0
// ============================================================================
module chacha_block_sequencer #(
  parameter int BLK_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic clk,
  input  wire logic rst_n,
  chacha_block_sequencer_if.slave bus
);
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_CORE = 3'd2,
    DRAIN     = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t           state;
  logic [BLK_W-1:0] remaining;
  logic [WD_W-1:0]  watchdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      remaining        <= '0;
      watchdog         <= '0;
      bus.job_ready    <= 1'b1;
      bus.core_start   <= 1'b0;
      bus.core_counter <= '0;
      bus.blk_valid    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.blocks_done  <= '0;
      bus.err_wrap     <= 1'b0;
      bus.err_timeout  <= 1'b0;
      bus.err_abort    <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      bus.done       <= 1'b0;
      // Abort outranks every other transition while a job is active
      if ((state == START || state == WAIT_CORE || state == DRAIN) && bus.abort) begin
        bus.err_abort <= 1'b1;
        bus.blk_valid <= 1'b0;
        bus.busy      <= 1'b0;
        bus.done      <= 1'b1;
        state         <= FINISH;
      end else begin
        case (state)
          IDLE: begin
            if (bus.job_valid && bus.job_ready) begin
              remaining        <= bus.job_blocks;
              bus.core_counter <= bus.job_counter;
              bus.blocks_done  <= '0;
              bus.err_wrap     <= 1'b0;
              bus.err_timeout  <= 1'b0;
              bus.err_abort    <= 1'b0;
              bus.job_ready    <= 1'b0;
              if (bus.job_blocks == '0) begin
                bus.done <= 1'b1;
                state    <= FINISH;
              end else begin
                bus.busy <= 1'b1;
                state    <= START;
              end
            end
          end
          START: begin
            if (!bus.core_busy) begin
              bus.core_start <= 1'b1;
              watchdog       <= '0;
              state          <= WAIT_CORE;
            end
          end
          WAIT_CORE: begin
            watchdog <= watchdog + WD_W'(1);
            if (bus.core_done) begin
              bus.blk_valid <= 1'b1;
              state         <= DRAIN;
            end else if (watchdog == WD_LAST) begin
              bus.err_timeout <= 1'b1;
              bus.busy        <= 1'b0;
              bus.done        <= 1'b1;
              state           <= FINISH;
            end
          end
          DRAIN: begin
            if (bus.blk_ready) begin
              bus.blk_valid   <= 1'b0;
              bus.blocks_done <= bus.blocks_done + BLK_W'(1);
              remaining       <= remaining - BLK_W'(1);
              if (remaining == BLK_W'(1)) begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= FINISH;
              end else if (&bus.core_counter) begin
                // The block counter must never wrap back to zero
                bus.err_wrap <= 1'b1;
                bus.busy     <= 1'b0;
                bus.done     <= 1'b1;
                state        <= FINISH;
              end else begin
                bus.core_counter <= bus.core_counter + 32'd1;
                state            <= START;
              end
            end
          end
          FINISH: begin
            bus.job_ready <= 1'b1;
            state         <= IDLE;
          end
          default: begin
            bus.job_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_chacha_block_sequencer.sv
`default_nettype none
// ============================================================================
// tb_chacha_block_sequencer : randomized job runs checked against a job-level reference model
// Rev 1.0
// ============================================================================
module tb_chacha_block_sequencer;
  localparam int BLK_W = 16;
  localparam int TOUT  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   overlap_cnt = 0;

  chacha_block_sequencer_if #(.BLK_W(BLK_W)) bif();

  chacha_block_sequencer #(.BLK_W(BLK_W), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.core_start) start_cnt++;
    if (bif.done) done_cnt++;
    if (bif.core_start && bif.blk_valid) overlap_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_flags"}, {bif.job_ready, bif.core_start, bif.blk_valid, bif.busy, bif.done,
                          bif.err_wrap, bif.err_timeout, bif.err_abort}, 8'h80);
    chk({tag, "_core_counter"}, bif.core_counter, 0);
    chk({tag, "_blocks_done"}, bif.blocks_done, 0);
  endtask

  // Job-level model: blocks served = min(job_blocks, room before 2^32), trimmed by abort/timeout
  task automatic run_job(input logic [31:0] ctr, input int nblk, input int lat_min, input int lat_max,
                         input int stall_max, input int abort_blk, input bit abort_drain,
                         input int busy_hold);
    longint      room;
    int          exp_blk, exp_starts, served, lat, stall, cyc, start_cyc, first_start, starts0;
    bit          exp_wrap, exp_abort, exp_tout, got_done, hold_chk;
    logic [31:0] exp_ctr;
    room     = 64'h1_0000_0000 - 64'(ctr);
    exp_tout = (lat_min >= TOUT) && (nblk > 0);
    exp_wrap = longint'(nblk) > room;
    exp_blk  = exp_wrap ? int'(room) : nblk;
    exp_abort = 1'b0;
    if (exp_tout) begin
      exp_blk  = 0;
      exp_wrap = 1'b0;
    end else if (abort_blk >= 0 && abort_blk < exp_blk) begin
      exp_blk   = abort_blk;
      exp_wrap  = 1'b0;
      exp_abort = 1'b1;
    end
    exp_starts = exp_tout ? 1 : (exp_abort ? abort_blk + 1 : exp_blk);

    starts0 = start_cnt; served = 0; lat = -1; stall = 0; cyc = 0;
    start_cyc = -1; first_start = -1; got_done = 1'b0; hold_chk = 1'b0;
    bif.job_valid = 1'b1; bif.job_blocks = BLK_W'(nblk); bif.job_counter = ctr;
    while (cyc < 3000) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        chk("accept_state", {bif.job_ready, bif.busy, bif.done, bif.err_wrap, bif.err_timeout,
                             bif.err_abort}, {1'b0, nblk != 0, nblk == 0, 3'b000});
        chk("accept_blocks_done", bif.blocks_done, 0);
      end
      if (bif.done) begin
        got_done = 1'b1;
        break;
      end
      bif.job_valid = 1'b0; bif.core_done = 1'b0; bif.abort = 1'b0; bif.blk_ready = 1'b0;
      bif.core_busy = (cyc <= busy_hold);
      if (hold_chk) chk("blk_valid_held", bif.blk_valid, 1);
      hold_chk = 1'b0;
      exp_ctr = ctr + 32'(served);
      if (bif.core_start) begin
        chk("core_counter_at_start", bif.core_counter, exp_ctr);
        if (first_start < 0) first_start = cyc;
        start_cyc = cyc;
        lat = $urandom_range(lat_max, lat_min);
        if (served == abort_blk && !abort_drain) begin
          bif.abort = 1'b1;
          lat = -1;
        end
      end
      if (lat == 0) begin
        bif.core_done = 1'b1;
        lat = -1;
        stall = $urandom_range(stall_max, 0);
        chk("core_counter_at_done", bif.core_counter, exp_ctr);
      end else if (lat > 0) begin
        lat--;
      end
      if (bif.blk_valid) begin
        if (served == abort_blk && abort_drain) begin
          bif.abort = 1'b1;
          bif.blk_ready = 1'b1;
        end else if (stall > 0) begin
          stall--;
          hold_chk = 1'b1;
        end else begin
          bif.blk_ready = 1'b1;
          served++;
        end
      end
    end
    bif.job_valid = 1'b0; bif.core_done = 1'b0; bif.abort = 1'b0;
    bif.blk_ready = 1'b0; bif.core_busy = 1'b0;

    chk("job_done_seen", got_done, 1);
    chk("blocks_done", bif.blocks_done, exp_blk);
    chk("err_flags", {bif.err_wrap, bif.err_timeout, bif.err_abort}, {exp_wrap, exp_tout, exp_abort});
    chk("core_start_count", start_cnt - starts0, exp_starts);
    chk("busy_blk_valid_at_done", {bif.busy, bif.blk_valid}, 2'b00);
    chk("no_start_with_blk_valid", overlap_cnt, 0);
    if (nblk > 0) chk("first_start_latency", first_start, busy_hold + 2);
    if (exp_tout) chk("timeout_latency", cyc - start_cyc, TOUT);

    tick();
    chk("idle_after_finish", {bif.done, bif.job_ready, bif.busy, bif.blk_valid}, 4'b0100);
    chk("blocks_done_hold", bif.blocks_done, exp_blk);

    if (exp_abort) begin
      tick();
      bif.core_done = 1'b1;
      tick();
      bif.core_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
        chk("stale_done_ignored", {bif.blk_valid, bif.busy, bif.job_ready, bif.done,
                                   bif.err_abort}, 5'b00101);
        chk("stale_blocks_done", bif.blocks_done, exp_blk);
        tick();
      end
    end
  endtask

  task automatic reset_in_drain();
    int cyc;
    int d0;
    cyc = 0;
    bif.job_valid = 1'b1; bif.job_blocks = BLK_W'(3); bif.job_counter = 32'h77;
    while (!bif.blk_valid && cyc < 100) begin
      tick();
      cyc++;
      bif.job_valid = 1'b0;
      bif.core_done = bif.core_start;
    end
    bif.core_done = 1'b0;
    chk("drain_reached", bif.blk_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_in_drain");
    d0 = done_cnt;
    repeat (3) tick();
    chk("no_done_during_reset", done_cnt - d0, 0);
    check_reset("reset_held");
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {bif.job_ready, bif.busy}, 2'b10);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.job_valid = 1'b0; bif.job_blocks = '0; bif.job_counter = '0; bif.abort = 1'b0;
    bif.core_busy = 1'b0; bif.core_done = 1'b0; bif.blk_ready = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();
    check_reset("post_reset_idle");

    run_job(32'h1, 1, 10, 10, 0, -1, 1'b0, 0);              // single block
    run_job(32'd5, 4, 0, 8, 3, -1, 1'b0, 0);                // backpressure, counters 5..8
    run_job(32'hFFFF_FFFE, 3, 0, 5, 1, -1, 1'b0, 0);        // counter limit
    run_job(32'd100, 2, 99, 99, 0, -1, 1'b0, 0);            // core never completes
    run_job($urandom, 3, 0, 6, 2, -1, 1'b0, 0);             // clears previous timeout
    run_job(32'd20, 8, 0, 6, 1, 1, 1'b0, 0);                // abort in WAIT_CORE of block 2
    run_job(32'd40, 5, 0, 4, 2, 2, 1'b1, 0);                // abort coinciding with blk_ready
    run_job(32'd7, 0, 0, 0, 0, -1, 1'b0, 0);                // empty job
    run_job(32'd9, 2, 0, 3, 0, -1, 1'b0, 3);                // core_busy delays start
    run_job(32'd11, 2, TOUT - 1, TOUT - 1, 0, -1, 1'b0, 0); // done coincides with timeout

    for (int j = 0; j < 6; j++) begin
      logic [31:0] c;
      c = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3, 0))) : $urandom;
      run_job(c, $urandom_range(5, 1), 0, 12, 3, -1, 1'b0, 0);
    end

    reset_in_drain();
    run_job(32'd3, 2, 0, 4, 1, -1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
